clk_div_ctrl: RTL

Runtime-reprogrammable integer clock divider with 50 % duty cycle for both even and odd ratios. Odd ratios use a dual-edge scheme: a posedge phase ORed with a negedge-delayed copy. A valid/ready configuration port accepts new divide ratios. The controller applies each new ratio only at an output-period boundary, so ratio changes never glitch `clk_out`. The block sits between the register/config logic and any consumer of a derived clock.

---
 rtl/clk_div_pkg.sv | 27 ++
 rtl/clk_div_core.sv | 46 ++++
 rtl/clk_div_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the runtime-reprogrammable clock divider.
// Define CLK_DIV_ODD_EN to allow odd ratios through the dual-edge path.
package clk_div_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam int unsigned DIV_MIN = 2;

  // An odd reset ratio needs the dual-edge path; the even-only build defaults to 8.
`ifdef CLK_DIV_ODD_EN
  localparam int unsigned DIV_DEFAULT_INIT = 7;
`else
  localparam int unsigned DIV_DEFAULT_INIT = 8;
`endif

  function automatic logic div_legal(input int unsigned n);
`ifdef CLK_DIV_ODD_EN
    return n >= DIV_MIN;
`else
    return (n >= DIV_MIN) && (n[0] == 1'b0);
`endif
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Divider datapath: posedge counter and high-phase flop, plus the negedge
// tail flop and OR combine for odd ratios (present only with CLK_DIV_ODD_EN).
module clk_div_core #(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  output logic             tc_c,
  output logic             clk_out
);

  logic [DIV_W-1:0] cnt_p;
  logic [DIV_W-1:0] half;
  logic             clk_p;

  assign half = div >> 1;
  assign tc_c = (cnt_p == (div - DIV_W'(1)));

  // High for the first H counts of each period; low at terminal count.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_p <= '0;
      clk_p <= 1'b0;
    end else begin
      clk_p <= (cnt_p < half);
      cnt_p <= (load || tc_c) ? '0 : cnt_p + DIV_W'(1);
    end
  end

`ifdef CLK_DIV_ODD_EN
  logic clk_n;

  // Half-cycle delayed copy stretches the high phase to H + 0.5 cycles.
  always_ff @(negedge clk_in or negedge rst) begin
    if (!rst) clk_n <= 1'b0;
    else      clk_n <= clk_p;
  end

  assign clk_out = clk_p | (div[0] & clk_n);
`else
  assign clk_out = clk_p;
`endif

endmodule

// File: rtl/clk_div_ctrl.sv
// Ratio controller: valid/ready config port, legality check and RUN/PEND FSM
// that applies a new ratio only at an output-period boundary.
// Optional odd-ratio support is enabled by defining CLK_DIV_ODD_EN.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = 4,
  parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_INIT
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             busy,
  output logic [DIV_W-1:0] div_active,
  output logic             clk_out
);

  state_t           state;
  state_t           state_nx;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] pend_nx;
  logic [DIV_W-1:0] div_nx;
  logic             err_nx;
  logic             load_c;
  logic             tc_c;
  logic             accept_c;
  logic             legal_c;

  assign accept_c = cfg_valid & cfg_ready;
  assign legal_c  = div_legal(32'(cfg_div));

  // Next-state and datapath-update decode.
  always_comb begin
    state_nx = state;
    pend_nx  = pend_div;
    div_nx   = div_active;
    err_nx   = 1'b0;
    load_c   = 1'b0;
    case (state)
      RUN: begin
        if (accept_c) begin
          if (legal_c) begin
            pend_nx  = cfg_div;
            state_nx = PEND;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      PEND: begin
        if (tc_c) begin
          load_c   = 1'b1;
          div_nx   = pend_div;
          state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      pend_div   <= '0;
      div_active <= DIV_W'(DIV_DEFAULT);
      cfg_err    <= 1'b0;
      cfg_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      pend_div   <= pend_nx;
      div_active <= div_nx;
      cfg_err    <= err_nx;
      cfg_ready  <= (state_nx == RUN);
      busy       <= (state_nx == PEND);
    end
  end

  clk_div_core #(
    .DIV_W(DIV_W)
  ) u_core (
    .clk_in (clk_in),
    .rst    (rst),
    .div    (div_active),
    .load   (load_c),
    .tc_c   (tc_c),
    .clk_out(clk_out)
  );

endmodule
